// File: rtl/float2int.sv
// float2int: pipelined IEEE-754 binary32 -> signed int32 converter (Versat unit).
// One float per cycle in, saturated two's-complement integer out 4 cycles
// after the sampling edge. A sticky overflow flag records any saturation or
// NaN seen since the last run pulse or reset.
// Optional build macro FLOAT2INT_ROUND_EN selects round-to-nearest-even;
// without it the converter truncates toward zero.
module float2int #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    (* versat_latency = 4 *)
    output logic [DATA_W-1:0] out0,
    output logic              ovf
);

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

`ifdef FLOAT2INT_ROUND_EN
    // With rounding, u == -1 can still round up to 1, so it is shifted too.
    localparam logic signed [8:0] U_MIN = -9'sd1;
`else
    localparam logic signed [8:0] U_MIN = 9'sd0;
`endif

    // Input sampling register
    logic [31:0] in_r;

    // Stage 1 registers: unpacked fields and class
    logic        s1_sign_r;
    logic [7:0]  s1_exp_r;
    logic [23:0] s1_mant_r;
    cls_t        s1_cls_r;
    logic        s1_minint_r;
    cls_t        cls_s;

    // Stage 2 registers: shift plan and saturate decision
    logic        s2_sign_r;
    logic [23:0] s2_mant_r;
    logic        s2_zero_r;
    logic        s2_sat_r;
    logic        s2_flag_r;
    logic        s2_left_r;
    logic [4:0]  s2_shamt_r;
    logic signed [8:0] u_s;
    logic        sign_s;
    logic        zero_s;
    logic        sat_s;
    logic        flag_s;
    logic        left_s;
    logic [4:0]  shamt_s;

    // Stage 3 registers: shifted magnitude
    logic        s3_sign_r;
    logic        s3_zero_r;
    logic        s3_sat_r;
    logic        s3_flag_r;
    logic [31:0] s3_mag_r;
    logic [31:0] mag_s;
`ifdef FLOAT2INT_ROUND_EN
    logic        s3_guard_r;
    logic        s3_sticky_r;
    logic [55:0] rext_s;
    logic        guard_s;
    logic        sticky_s;
`endif

    // Stage 4 signals
    logic [31:0] rnd_s;
    logic [31:0] signed_s;
    logic [31:0] res_s;
    logic        sat4_r;

    // Capture the operand every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r <= 32'd0;
        end else begin
            in_r <= in0;
        end
    end

    // Classify the sampled operand by its exponent and fraction fields
    always_comb begin
        cls_s = CLS_NORM;
        if (in_r[30:23] == 8'd0) begin
            cls_s = CLS_ZERO;
        end else if (in_r[30:23] == 8'hFF) begin
            if (in_r[22:0] == 23'd0) begin
                cls_s = CLS_INF;
            end else begin
                cls_s = CLS_NAN;
            end
        end else begin
            cls_s = CLS_NORM;
        end
    end

    // S1: register unpacked sign, exponent, mantissa with hidden bit, class
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign_r   <= 1'b0;
            s1_exp_r    <= 8'd0;
            s1_mant_r   <= 24'd0;
            s1_cls_r    <= CLS_ZERO;
            s1_minint_r <= 1'b0;
        end else begin
            s1_sign_r   <= in_r[31];
            s1_exp_r    <= in_r[30:23];
            s1_mant_r   <= {1'b1, in_r[22:0]};
            s1_cls_r    <= cls_s;
            s1_minint_r <= (in_r == 32'hCF00_0000);
        end
    end

    // S2 plan: pick shift direction/amount or force zero/saturation
    always_comb begin
        u_s     = $signed({1'b0, s1_exp_r}) - 9'sd127;
        sign_s  = s1_sign_r;
        zero_s  = 1'b0;
        sat_s   = 1'b0;
        flag_s  = 1'b0;
        left_s  = 1'b0;
        shamt_s = 5'd0;
        case (s1_cls_r)
            CLS_ZERO: begin
                zero_s = 1'b1;
            end
            CLS_INF: begin
                sat_s  = 1'b1;
                flag_s = 1'b1;
            end
            CLS_NAN: begin
                // NaN of either sign maps to the most negative integer
                sat_s  = 1'b1;
                flag_s = 1'b1;
                sign_s = 1'b1;
            end
            CLS_NORM: begin
                if (u_s >= 9'sd31) begin
                    sat_s  = 1'b1;
                    // -2^31 is exactly representable, so it is not an overflow
                    flag_s = ~s1_minint_r;
                end else if (u_s >= 9'sd23) begin
                    left_s  = 1'b1;
                    shamt_s = u_s[4:0] - 5'd23;
                end else if (u_s >= U_MIN) begin
                    // Modulo-32 arithmetic gives 24 for u == -1
                    shamt_s = 5'd23 - u_s[4:0];
                end else begin
                    zero_s = 1'b1;
                end
            end
            default: begin
                zero_s = 1'b1;
            end
        endcase
    end

    // S2: register the shift plan alongside the mantissa
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sign_r  <= 1'b0;
            s2_mant_r  <= 24'd0;
            s2_zero_r  <= 1'b0;
            s2_sat_r   <= 1'b0;
            s2_flag_r  <= 1'b0;
            s2_left_r  <= 1'b0;
            s2_shamt_r <= 5'd0;
        end else begin
            s2_sign_r  <= sign_s;
            s2_mant_r  <= s1_mant_r;
            s2_zero_r  <= zero_s;
            s2_sat_r   <= sat_s;
            s2_flag_r  <= flag_s;
            s2_left_r  <= left_s;
            s2_shamt_r <= shamt_s;
        end
    end

`ifdef FLOAT2INT_ROUND_EN
    // S3 shift: the mantissa sits above 24 fraction bits so the bits shifted
    // out on the right supply guard and sticky
    always_comb begin
        rext_s = {8'd0, s2_mant_r, 24'd0} >> s2_shamt_r;
        if (s2_left_r) begin
            mag_s    = {8'd0, s2_mant_r} << s2_shamt_r;
            guard_s  = 1'b0;
            sticky_s = 1'b0;
        end else begin
            mag_s    = rext_s[55:24];
            guard_s  = rext_s[23];
            sticky_s = |rext_s[22:0];
        end
    end
`else
    // S3 shift: truncating barrel shift, discarded bits are simply dropped
    always_comb begin
        if (s2_left_r) begin
            mag_s = {8'd0, s2_mant_r} << s2_shamt_r;
        end else begin
            mag_s = {8'd0, s2_mant_r} >> s2_shamt_r;
        end
    end
`endif

    // S3: register the integer magnitude and control flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_sign_r   <= 1'b0;
            s3_zero_r   <= 1'b0;
            s3_sat_r    <= 1'b0;
            s3_flag_r   <= 1'b0;
            s3_mag_r    <= 32'd0;
`ifdef FLOAT2INT_ROUND_EN
            s3_guard_r  <= 1'b0;
            s3_sticky_r <= 1'b0;
`endif
        end else begin
            s3_sign_r   <= s2_sign_r;
            s3_zero_r   <= s2_zero_r;
            s3_sat_r    <= s2_sat_r;
            s3_flag_r   <= s2_flag_r;
            s3_mag_r    <= mag_s;
`ifdef FLOAT2INT_ROUND_EN
            s3_guard_r  <= guard_s;
            s3_sticky_r <= sticky_s;
`endif
        end
    end

    // S4 arithmetic: round, negate, then choose zero / saturated / value
    always_comb begin
`ifdef FLOAT2INT_ROUND_EN
        // Ties go to the even neighbour; magnitudes here never reach 2^31
        if (s3_guard_r & (s3_sticky_r | s3_mag_r[0])) begin
            rnd_s = s3_mag_r + 32'd1;
        end else begin
            rnd_s = s3_mag_r;
        end
`else
        rnd_s = s3_mag_r;
`endif
        if (s3_sign_r) begin
            signed_s = 32'd0 - rnd_s;
        end else begin
            signed_s = rnd_s;
        end
        if (s3_zero_r) begin
            res_s = 32'd0;
        end else if (s3_sat_r) begin
            res_s = s3_sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            res_s = signed_s;
        end
    end

    // S4: register the result and its overflow marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0   <= 32'd0;
            sat4_r <= 1'b0;
        end else begin
            out0   <= res_s;
            sat4_r <= s3_flag_r;
        end
    end

    // Sticky overflow: run clears it, a saturation leaving S4 sets it (set wins)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (ovf & ~run) | sat4_r;
        end
    end

endmodule
